// File: rtl/adder_pkg.sv
// Shared definitions for the word-serial adder: FSM encoding, default
// geometry and the word-counter width rule.
package adder_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_WORDS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADD   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Counter width for a given number of words per operand, never below 1.
   function automatic int cnt_bits(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/fulladder.sv
// Combinational word-wide full adder: osum/ocout = ia + ib + icin.
module fulladder #(
   parameter int MP_WIDTH = 4
) (
   input  logic [MP_WIDTH-1:0] ia,
   input  logic [MP_WIDTH-1:0] ib,
   input  logic                icin,
   output logic [MP_WIDTH-1:0] osum,
   output logic                ocout
);

   // Zero-extend every operand so the carry-out lands in the extra bit.
   assign {ocout, osum} = {1'b0, ia} + {1'b0, ib} + {{MP_WIDTH{1'b0}}, icin};

endmodule

// File: rtl/serial_adder.sv
// Word-serial multi-word adder. Operands arrive LSW first over a
// valid/ready stream; each accepted word pair is added with the running
// carry and the registered sum is presented on a valid/ready output.
// The final carry-out and a one-cycle done pulse follow the last word.
module serial_adder
   import adder_pkg::*;
#(
   parameter int MP_WIDTH = DEF_WIDTH,
   parameter int MP_WORDS = DEF_WORDS
) (
   input  logic                iclk,
   input  logic                irst_n,
   input  logic                istart,
   input  logic                icin,
   input  logic                ivalid,
   input  logic [MP_WIDTH-1:0] ia,
   input  logic [MP_WIDTH-1:0] ib,
   output logic                oready,
   output logic [MP_WIDTH-1:0] osum,
   output logic                ovalid,
   input  logic                iready,
   output logic                ocout,
   output logic                odone
);

   localparam int            CW   = cnt_bits(MP_WORDS);
   localparam logic [CW-1:0] LAST = CW'(MP_WORDS - 1);

   state_t                state_q;
   state_t                state_d;
   logic                  carry_q;
   logic [CW-1:0]         cnt_q;
   logic [MP_WIDTH-1:0]   fa_sum;
   logic                  fa_cout;
   logic                  accept;
   logic                  consume;
   logic                  last_word;

   fulladder #(
      .MP_WIDTH (MP_WIDTH)
   ) u_fulladder (
      .ia    (ia),
      .ib    (ib),
      .icin  (carry_q),
      .osum  (fa_sum),
      .ocout (fa_cout)
   );

   // Input side may take a word only while adding and the output slot is free or draining.
   assign oready    = (state_q == ST_ADD) && (!ovalid || iready);
   assign accept    = ivalid && oready;
   assign consume   = ovalid && iready;
   assign last_word = (cnt_q == LAST);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> ADD on start, ADD -> FLUSH on last word, FLUSH -> IDLE on final consume.
   // NOTE: state_d gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (istart)                 state_d = ST_ADD;
         ST_ADD:   if (accept && last_word)    state_d = ST_FLUSH;
         ST_FLUSH: if (consume)                state_d = ST_IDLE;
         default:                              state_d = ST_IDLE;
      endcase
   end

   // Datapath: carry, word counter, output word register, carry-out and done pulse.
   // NOTE: only control/data flops exist here (no memory arrays), so every
   // register is cleared by the asynchronous reset to abort cleanly.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         carry_q <= 1'b0;
         cnt_q   <= '0;
         osum    <= '0;
         ovalid  <= 1'b0;
         ocout   <= 1'b0;
         odone   <= 1'b0;
      end else begin
         odone <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (istart) begin
                  carry_q <= icin;
                  cnt_q   <= '0;
                  ocout   <= 1'b0;
               end
            end
            ST_ADD: begin
               if (accept) begin
                  osum    <= fa_sum;
                  ovalid  <= 1'b1;
                  carry_q <= fa_cout;
                  // Hold on the last word so the counter never wraps within an operation.
                  if (!last_word) cnt_q <= cnt_q + CW'(1);
               end else if (consume) begin
                  ovalid <= 1'b0;
               end
            end
            ST_FLUSH: begin
               if (consume) begin
                  ovalid <= 1'b0;
                  odone  <= 1'b1;
                  ocout  <= carry_q;
               end
            end
            default: begin
               ovalid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (MP_WIDTH=4, MP_WORDS=2). The
// reference treats each operand as one 8-bit number: the expected sum words
// and carry-out are slices of a + b + cin.
module tb_serial_adder;

   localparam int W = 4;
   localparam int N = 2;

   logic         clk;
   logic         irst_n;
   logic         istart;
   logic         icin;
   logic         ivalid;
   logic [W-1:0] ia;
   logic [W-1:0] ib;
   logic         oready;
   logic [W-1:0] osum;
   logic         ovalid;
   logic         iready;
   logic         ocout;
   logic         odone;

   int pass_cnt  = 0;
   int total_cnt = 0;

   serial_adder #(
      .MP_WIDTH (W),
      .MP_WORDS (N)
   ) dut (
      .iclk   (clk),
      .irst_n (irst_n),
      .istart (istart),
      .icin   (icin),
      .ivalid (ivalid),
      .ia     (ia),
      .ib     (ib),
      .oready (oready),
      .osum   (osum),
      .ovalid (ovalid),
      .iready (iready),
      .ocout  (ocout),
      .odone  (odone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Runs one full operation starting at the current (post-negedge) time.
   // stall: iready held low for that many cycles once the first sum is pending.
   // rnd: randomise ivalid/iready; poke: assert istart with icin=1 during ADD.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input int stall, input bit rnd, input bit poke, input string name);
      logic [8:0] total;
      logic [3:0] exp_q[$];
      int         acc_n;
      int         out_n;
      int         cyc;
      int         stall_left;
      bit         done_seen;
      bit         exp_rdy;
      bit         exp_odone;
      bit         exp_v;
      total      = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      acc_n      = 0;
      out_n      = 0;
      cyc        = 0;
      stall_left = stall;
      done_seen  = 0;

      istart = 1'b1;
      icin   = cin;
      ivalid = 1'b0;
      iready = 1'b1;
      @(negedge clk);
      istart = 1'b0;
      icin   = 1'b0;
      total_cnt++;
      if (ocout !== 1'b0) $display("FAIL %s start_ocout: got %b want 0", name, ocout);
      else pass_cnt++;

      while (!done_seen && cyc < 60) begin
         istart = poke && (acc_n == 1);
         icin   = poke;
         if (acc_n < N) begin
            ivalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ia     = a[acc_n*W +: W];
            ib     = b[acc_n*W +: W];
         end else begin
            ivalid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            ia     = 4'($urandom);
            ib     = 4'($urandom);
         end
         if (exp_q.size() != 0 && stall_left > 0) begin
            iready = 1'b0;
            stall_left--;
         end else begin
            iready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         #1;
         exp_v     = (exp_q.size() != 0);
         exp_rdy   = (acc_n < N) && (!exp_v || iready);
         exp_odone = (out_n == N);

         total_cnt++;
         if (ovalid !== exp_v) $display("FAIL %s ovalid c%0d: got %b want %b", name, cyc, ovalid, exp_v);
         else pass_cnt++;
         total_cnt++;
         if (oready !== exp_rdy) $display("FAIL %s oready c%0d: got %b want %b", name, cyc, oready, exp_rdy);
         else pass_cnt++;
         total_cnt++;
         if (odone !== exp_odone) $display("FAIL %s odone c%0d: got %b want %b", name, cyc, odone, exp_odone);
         else pass_cnt++;
         if (exp_v) begin
            total_cnt++;
            if (osum !== exp_q[0]) $display("FAIL %s osum c%0d: got %h want %h", name, cyc, osum, exp_q[0]);
            else pass_cnt++;
         end
         if (exp_odone) begin
            done_seen = 1;
            total_cnt++;
            if (ocout !== total[8]) $display("FAIL %s ocout: got %b want %b", name, ocout, total[8]);
            else pass_cnt++;
         end

         if (exp_v && iready) begin
            void'(exp_q.pop_front());
            out_n++;
         end
         if (ivalid && exp_rdy) begin
            exp_q.push_back(total[acc_n*W +: W]);
            acc_n++;
         end
         @(negedge clk);
         cyc++;
      end

      if (!done_seen) begin
         total_cnt++;
         $display("FAIL %s timeout: got no odone want odone within 60 cycles", name);
      end

      istart = 1'b0;
      icin   = 1'b0;
      ivalid = 1'b0;
      iready = 1'b1;
      #1;
      total_cnt++;
      if (odone !== 1'b0) $display("FAIL %s odone_pulse: got %b want 0", name, odone);
      else pass_cnt++;
      total_cnt++;
      if (ocout !== total[8]) $display("FAIL %s ocout_hold: got %b want %b", name, ocout, total[8]);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      irst_n = 1'b0;
      istart = 1'b0;
      icin   = 1'b0;
      ivalid = 1'b0;
      ia     = '0;
      ib     = '0;
      iready = 1'b0;
      #12;
      total_cnt++;
      if ({osum, ovalid, ocout, odone, oready} !== 8'h00)
         $display("FAIL reset_outputs: got osum=%h ovalid=%b ocout=%b odone=%b oready=%b want all 0",
                  osum, ovalid, ocout, odone, oready);
      else pass_cnt++;
      @(negedge clk);
      irst_n = 1'b1;
      // Operand words offered while idle must be ignored.
      for (int i = 0; i < 4; i++) begin
         ivalid = 1'b1;
         ia     = 4'($urandom);
         ib     = 4'($urandom);
         iready = 1'($urandom_range(0, 1));
         @(negedge clk);
         #1;
         total_cnt++;
         if (ovalid !== 1'b0 || oready !== 1'b0 || osum !== 4'h0)
            $display("FAIL idle_ignore %0d: got ovalid=%b oready=%b osum=%h want 0 0 0", i, ovalid, oready, osum);
         else pass_cnt++;
      end
      ivalid = 1'b0;
      iready = 1'b1;
   endtask

   task automatic test_reset_mid();
      istart = 1'b1;
      icin   = 1'b1;
      @(negedge clk);
      istart = 1'b0;
      icin   = 1'b0;
      ivalid = 1'b1;
      ia     = 4'hF;
      ib     = 4'hA;
      iready = 1'b0;
      @(negedge clk);
      ivalid = 1'b0;
      #1;
      total_cnt++;
      if (ovalid !== 1'b1 || osum !== 4'hA)
         $display("FAIL rst_mid_first: got ovalid=%b osum=%h want 1 a", ovalid, osum);
      else pass_cnt++;
      irst_n = 1'b0;
      #1;
      total_cnt++;
      if ({osum, ovalid, ocout, odone, oready} !== 8'h00)
         $display("FAIL rst_mid_async: got osum=%h ovalid=%b ocout=%b odone=%b oready=%b want all 0",
                  osum, ovalid, ocout, odone, oready);
      else pass_cnt++;
      @(negedge clk);
      irst_n = 1'b1;
      iready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         total_cnt++;
         if (odone !== 1'b0 || ovalid !== 1'b0 || oready !== 1'b0)
            $display("FAIL rst_mid_quiet %0d: got odone=%b ovalid=%b oready=%b want 0 0 0", i, odone, ovalid, oready);
         else pass_cnt++;
      end
      run_op(8'h32, 8'h53, 1'b0, 0, 1'b0, 1'b0, "rst_mid_basic");
   endtask

   task automatic test_basic();
      run_op(8'h32, 8'h53, 1'b0, 0, 1'b0, 1'b0, "basic");
   endtask

   task automatic test_carry_chain();
      run_op(8'hFF, 8'h0A, 1'b1, 0, 1'b0, 1'b0, "carry");
   endtask

   task automatic test_backpressure();
      run_op(8'h32, 8'h53, 1'b0, 3, 1'b0, 1'b0, "backpressure");
   endtask

   task automatic test_ignored_start();
      run_op(8'h32, 8'h53, 1'b0, 0, 1'b0, 1'b1, "ignored_start");
   endtask

   task automatic test_back_to_back();
      run_op(8'hFF, 8'h0A, 1'b1, 0, 1'b0, 1'b0, "b2b_first");
      run_op(8'h32, 8'h53, 1'b0, 0, 1'b0, 1'b0, "b2b_second");
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'b1, 1'b0, "random");
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_basic();
      test_carry_chain();
      test_backpressure();
      test_ignored_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter MP_WIDTH, default 4, meaning the word width passed to the fulladder.
REQ-002 SHALL have parameter MP_WORDS, default 4, meaning words per operand (>=1).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 iclk  input  1  clock; all state updates on rising edge.
REQ-005 irst_n  input  1  asynchronous active-low reset.
REQ-006 istart  input  1  start pulse; sampled only in IDLE.
REQ-007 icin  input  1  initial carry-in, captured with istart.
REQ-008 ivalid  input  1  operand word valid.
REQ-009 ia  input  MP_WIDTH  operand A word, least-significant word (LSW) first.
REQ-010 ib  input  MP_WIDTH  operand B word, LSW first.
REQ-011 oready  output  1  operand word accepted when ivalid && oready.
REQ-012 osum  output  MP_WIDTH  registered sum word.
REQ-013 ovalid  output  1  osum valid.
REQ-014 iready  input  1  downstream accepts osum when ovalid && iready.
REQ-015 ocout  output  1  final carry-out of the whole operation.
REQ-016 odone  output  1  one-cycle pulse marking completion; ocout valid in that cycle.

Function
REQ-017 SHALL implement the FSM IDLE -> ADD -> FLUSH -> IDLE.
REQ-018 In IDLE, istart SHALL load the carry register with icin, clear the word counter, clear ocout and move to ADD.
REQ-019 istart SHALL be ignored in ADD and FLUSH.
REQ-020 In ADD, oready SHALL equal !ovalid || iready; in IDLE and FLUSH, oready SHALL be 0.
REQ-021 On an accepted word, the fulladder SHALL compute ia+ib+carry.
REQ-022 On an accepted word, osum SHALL register the sum, ovalid SHALL be set, the carry register SHALL load cout, and the counter SHALL increment.
REQ-023 Latency SHALL be 1 cycle from word accept to ovalid.
REQ-024 Throughput SHALL be 1 word/cycle while iready=1.
REQ-025 ovalid && !iready SHALL hold osum and ovalid stable.
REQ-026 ovalid && iready with no new accept SHALL clear ovalid next cycle.
REQ-027 Simultaneous output consume and input accept SHALL load the new word with no bubble.
REQ-028 The accept of word MP_WORDS-1 SHALL move the FSM to FLUSH; the counter SHALL NOT wrap within one operation.
REQ-029 In FLUSH, once the last osum is consumed (ovalid && iready), the FSM SHALL go to IDLE next cycle.
REQ-030 On that transition, odone SHALL be 1 for exactly one cycle and ocout SHALL equal the final carry.
REQ-031 ocout SHALL hold until the next accepted istart.
REQ-032 Sum words SHALL be modulo 2^MP_WIDTH; carry propagates only through the carry register.
REQ-033 The word counter SHALL be $clog2(MP_WORDS) bits, minimum 1.
REQ-034 ivalid in IDLE or FLUSH SHALL have no effect.

Reset
REQ-035 irst_n low SHALL immediately force FSM=IDLE and clear osum, ovalid, ocout, odone, carry and counter to 0; oready is 0 as IDLE requires.
REQ-036 Reset mid-operation SHALL discard all partial results; no odone SHALL be issued for the aborted operation.
REQ-037 After reset release, the first istart SHALL start a clean operation.

Structure
REQ-038 The FSM state encoding and the default MP_WIDTH/MP_WORDS values SHALL live in a shared package, adder_pkg.
REQ-039 The module SHALL instantiate the existing fulladder sub-module (MP_WIDTH, ports ia/ib/icin/osum/ocout) as its only sub-module, fed by ia, ib and the carry register.

Verification (MP_WIDTH=4, MP_WORDS=2)
REQ-040 Basic add: istart, icin=0; words (ia,ib) = (2,3), (3,5); iready=1 -> osum 5 then 8, each 1 cycle after accept; ocout=0 with odone.
REQ-041 Carry chain: icin=1; words (F,A), (F,0) -> osum A then 0; ocout=1 with odone.
REQ-042 Back-pressure: basic add case with iready=0 for 3 cycles after the first ovalid -> osum holds 5, oready=0, the second word is stalled and not lost; final results are unchanged.
REQ-043 Reset mid-operation: irst_n low after the first word of the carry-chain case -> all outputs 0 and IDLE immediately; no odone; a following basic add run gives correct results.
REQ-044 Ignored start: istart=1 with icin=1 during ADD of the basic add case -> results unchanged (5, 8, ocout=0).
REQ-045 Back-to-back: istart one cycle after odone -> the second operation runs correctly, and ocout is cleared at the new start.
